// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/result bundle between an ALU client and alu_exec
interface alu_exec_if;
    logic        start;
    logic [2:0]  aluF;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        busy;
    logic        done;
    logic        dbz;

    modport master (
        output start, aluF, a, b,
        input  result, hi, zero, busy, done, dbz
    );

    modport slave (
        input  start, aluF, a, b,
        output result, hi, zero, busy, done, dbz
    );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - 32-bit ALU with single-cycle logic ops and iterative MULT/DIV
module alu_exec (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_MULT = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_opd;
    logic [63:0] r_acc;
    logic [31:0] r_result;
    logic [31:0] r_hi;
    logic        r_zero;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_hi;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_iter_next;
    logic [31:0] w_single;

    // MUL: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
    // DIV: r_acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
        w_mul_next  = {w_mul_sum, r_acc[31:1]};
        w_div_hi    = r_acc[63:31];
        w_div_ge    = (w_div_hi >= {1'b0, r_opd});
        w_div_diff  = w_div_hi[31:0] - r_opd;
        w_div_next  = {(w_div_ge ? w_div_diff : w_div_hi[31:0]), r_acc[30:0], w_div_ge};
        w_iter_next = (r_state == MUL) ? w_mul_next : w_div_next;
    end

    always_comb begin
        w_single = 32'd0;
        case (bus.aluF)
            OP_ADD:  w_single = bus.a + bus.b;
            OP_SUB:  w_single = bus.a - bus.b;
            OP_AND:  w_single = bus.a & bus.b;
            OP_OR:   w_single = bus.a | bus.b;
            OP_SLT:  w_single = {31'd0, ($signed(bus.a) < $signed(bus.b))};
            default: w_single = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_opd    <= 32'd0;
            r_acc    <= 64'd0;
            r_result <= 32'd0;
            r_hi     <= 32'd0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.aluF)
                            OP_MULT: begin
                                r_state <= MUL;
                                r_busy  <= 1'b1;
                                r_cnt   <= 6'd32;
                                r_opd   <= bus.a;
                                r_acc   <= {32'd0, bus.b};
                            end
                            OP_DIV: begin
                                if (bus.b == 32'd0) begin
                                    r_result <= 32'hFFFF_FFFF;
                                    r_hi     <= bus.a;
                                    r_zero   <= 1'b0;
                                    r_dbz    <= 1'b1;
                                    r_done   <= 1'b1;
                                end else begin
                                    r_state <= DIV;
                                    r_busy  <= 1'b1;
                                    r_cnt   <= 6'd32;
                                    r_opd   <= bus.b;
                                    r_acc   <= {32'd0, bus.a};
                                end
                            end
                            OP_NOP: begin
                                r_dbz  <= 1'b0;
                                r_done <= 1'b1;
                            end
                            default: begin
                                r_result <= w_single;
                                r_zero   <= (w_single == 32'd0);
                                r_dbz    <= 1'b0;
                                r_done   <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    r_acc <= w_iter_next;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_result <= w_iter_next[31:0];
                        r_hi     <= w_iter_next[63:32];
                        r_zero   <= (w_iter_next[31:0] == 32'd0);
                        r_dbz    <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.hi     = r_hi;
    assign bus.zero   = r_zero;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.dbz    = r_dbz;
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - randomized self-checking bench for alu_exec against an arithmetic reference model
module tb_alu_exec;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] SLT = 3'd4, MULT = 3'd5, DIV = 3'd6, NOP = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_if bus();
    alu_exec dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] m_result, m_hi;
    logic        m_zero, m_dbz;

    task automatic model_reset();
        m_result = 32'd0; m_hi = 32'd0; m_zero = 1'b1; m_dbz = 1'b0;
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        case (op)
            ADD:  m_result = x + y;
            SUB:  m_result = x - y;
            AND_: m_result = x & y;
            OR_:  m_result = x | y;
            SLT:  m_result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            MULT: begin p = 64'(x) * 64'(y); m_result = p[31:0]; m_hi = p[63:32]; end
            DIV:  if (y == 0) begin m_result = 32'hFFFF_FFFF; m_hi = x; end
                  else begin m_result = x / y; m_hi = x % y; end
            default: ;
        endcase
        if (op != NOP) m_zero = (m_result == 32'd0);
        m_dbz = (op == DIV) && (y == 32'd0);
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] y);
        return (op == MULT || (op == DIV && y != 0)) ? 32 : 0;
    endfunction

    // Issue one op and wait (bounded) for done; operands are scrambled while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int l, output int nbusy, output bit t);
        bus.start = 1'b1; bus.aluF = op; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; l = 0; nbusy = 0; t = 1'b0;
        while (bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) nbusy++;
            if (l >= 40) begin t = 1'b1; break; end
            bus.a = $urandom; bus.b = $urandom; bus.aluF = 3'($urandom);
            @(negedge clk);
            l++;
        end
        if (bus.busy === 1'b1) nbusy++;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.aluF = NOP; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.result, bus.hi, bus.zero, bus.busy, bus.done, bus.dbz} !== {64'd0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got r=%h hi=%h z=%b busy=%b done=%b dbz=%b, want 0/0/1/0/0/0",
                     bus.result, bus.hi, bus.zero, bus.busy, bus.done, bus.dbz);
        end
        bus.start = 1'b1; bus.aluF = ADD; bus.a = 32'd1; bus.b = 32'd2;
        @(negedge clk);
        checks++;
        if ({bus.result, bus.done} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_priority: got r=%h done=%b, want r=0 done=0", bus.result, bus.done);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        model_reset();
        model(ADD, 32'd1, 32'd2);
        checks++;
        if ({bus.result, bus.done, bus.zero} !== {m_result, 1'b1, m_zero}) begin
            errors++;
            $display("FAIL first_start: got r=%h done=%b z=%b, want r=%h done=1 z=%b",
                     bus.result, bus.done, bus.zero, m_result, m_zero);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10] = '{ADD, SUB, SLT, SLT, MULT, DIV, NOP, DIV, AND_, OR_};
        logic [31:0] xs  [10] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                                  32'd100, 32'd3, 32'd9, 32'hF0F0_1234, 32'h0000_00F0};
        logic [31:0] ys  [10] = '{32'd1, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd7, 32'd4, 32'd0, 32'h0F0F_0000, 32'h0000_000F};
        int l, nb;
        bit t;
        for (int i = 0; i < 10; i++) begin
            model(ops[i], xs[i], ys[i]);
            run_op(ops[i], xs[i], ys[i], l, nb, t);
            checks++;
            if (t || l != exp_lat(ops[i], ys[i]) || nb != exp_lat(ops[i], ys[i])) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d timeout=%b, want %0d",
                         i, l, nb, t, exp_lat(ops[i], ys[i]));
            end
            checks++;
            if ({bus.result, bus.hi, bus.zero, bus.dbz} !== {m_result, m_hi, m_zero, m_dbz}) begin
                errors++;
                $display("FAIL directed_value[%0d]: got r=%h hi=%h z=%b dbz=%b, want r=%h hi=%h z=%b dbz=%b",
                         i, bus.result, bus.hi, bus.zero, bus.dbz, m_result, m_hi, m_zero, m_dbz);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL directed_single_pulse[%0d]: got done=%b, want 0", i, bus.done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] x, y;
        int l = 0, dones = 0;
        x = $urandom; y = $urandom;
        model(MULT, x, y);
        bus.start = 1'b1; bus.aluF = MULT; bus.a = x; bus.b = y;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin bus.start = 1'b1; bus.aluF = ADD; bus.a = 32'd1; bus.b = 32'd1; end
            else bus.start = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin dones++; if (dones == 1) l = c; end
        end
        checks++;
        if (dones != 1 || l != 32) begin
            errors++;
            $display("FAIL busy_ignore_done: got %0d done pulses first at edge %0d, want 1 at 32", dones, l);
        end
        checks++;
        if ({bus.result, bus.hi} !== {m_result, m_hi}) begin
            errors++;
            $display("FAIL busy_ignore_value: got hi:r=%h:%h, want %h:%h", bus.hi, bus.result, m_hi, m_result);
        end
    endtask

    task automatic test_abort();
        int dones = 0, nb = 0;
        bus.start = 1'b1; bus.aluF = MULT; bus.a = $urandom; bus.b = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) nb++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.done === 1'b1) dones++;
        rst = 1'b0;
        model_reset();
        checks++;
        if (dones != 0 || nb != 19) begin
            errors++;
            $display("FAIL abort_no_done: got %0d dones, %0d busy cycles, want 0 and 19", dones, nb);
        end
        checks++;
        if ({bus.result, bus.hi, bus.zero, bus.busy, bus.dbz} !== {64'd0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL abort_reset_values: got r=%h hi=%h z=%b busy=%b dbz=%b, want 0/0/1/0/0",
                     bus.result, bus.hi, bus.zero, bus.busy, bus.dbz);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sops [6] = '{ADD, SUB, AND_, OR_, SLT, NOP};
        logic [31:0] x, y;
        int l;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.aluF = sops[$urandom_range(0, 5)]; bus.a = $urandom; bus.b = $urandom;
            model(bus.aluF, bus.a, bus.b);
            @(negedge clk);
            checks++;
            if ({bus.done, bus.result, bus.zero, bus.dbz} !== {1'b1, m_result, m_zero, m_dbz}) begin
                errors++;
                $display("FAIL b2b[%0d]: got done=%b r=%h z=%b dbz=%b, want done=1 r=%h z=%b dbz=%b",
                         i, bus.done, bus.result, bus.zero, bus.dbz, m_result, m_zero, m_dbz);
            end
        end
        x = $urandom; y = $urandom;
        bus.aluF = MULT; bus.a = x; bus.b = y;
        model(MULT, x, y);
        @(negedge clk);
        bus.aluF = ADD; bus.a = 32'd10; bus.b = 32'd20;
        l = 0;
        while (bus.done !== 1'b1 && l < 40) begin @(negedge clk); l++; end
        checks++;
        if (l != 32 || {bus.result, bus.hi} !== {m_result, m_hi}) begin
            errors++;
            $display("FAIL b2b_mult: got lat=%0d hi:r=%h:%h, want 32 %h:%h", l, bus.hi, bus.result, m_hi, m_result);
        end
        model(ADD, 32'd10, 32'd20);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.result} !== {1'b1, m_result}) begin
            errors++;
            $display("FAIL b2b_after_busy: got done=%b r=%h, want done=1 r=%h", bus.done, bus.result, m_result);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] x, y;
        int l, nb;
        bit t;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            x = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 300));
                default: y = $urandom;
            endcase
            model(op, x, y);
            run_op(op, x, y, l, nb, t);
            checks++;
            if (t || l != exp_lat(op, y) || nb != exp_lat(op, y)
                || {bus.result, bus.hi, bus.zero, bus.dbz} !== {m_result, m_hi, m_zero, m_dbz}) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d busy=%0d r=%h hi=%h z=%b dbz=%b, want lat=%0d r=%h hi=%h z=%b dbz=%b",
                         i, op, x, y, l, nb, bus.result, bus.hi, bus.zero, bus.dbz,
                         exp_lat(op, y), m_result, m_hi, m_zero, m_dbz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
